// File: rtl/cgp_eval_pkg.sv
// cgp_eval_pkg
//   Shared definitions for the CGP fitness evaluator:
//     - eval_state_t : evaluator FSM states (IDLE, SETTLE, SAMPLE, DONE)
//     - DEF_N_IN / DEF_N_OUT : default individual input/output counts
//     - table_width() : bits in a full truth table (2^n_in * n_out)
//     - fit_width()   : bits needed to hold a fitness value 0..table_width
package cgp_eval_pkg;

  localparam int DEF_N_IN  = 4;
  localparam int DEF_N_OUT = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } eval_state_t;

  function automatic int table_width(input int n_in, input int n_out);
    return (1 << n_in) * n_out;
  endfunction

  // One extra code point so a perfect score (every bit matching) fits.
  function automatic int fit_width(input int n_in, input int n_out);
    return $clog2(table_width(n_in, n_out) + 1);
  endfunction

endpackage

// File: rtl/cgp_popcount.sv
// cgp_popcount
//   Combinational population count of a W-bit word.
//   Ports:
//     bits  : input word
//     count : number of set bits in bits, $clog2(W+1) wide
module cgp_popcount #(
  parameter  int W  = 4,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/cgp_fitness_eval.sv
// cgp_fitness_eval
//   Sequential fitness evaluator for an evolved CGP LUT-grid individual.
//   Sweeps all 2^N_IN input vectors onto the individual, holds each one for
//   SETTLE_CYCLES+1 cycles, samples the individual's outputs in the last of
//   those cycles and counts how many output bits agree with a target truth
//   table. The count is reported as the fitness.
//
//   Ports:
//     clk      : single clock, rising edge
//     rst_n    : synchronous reset, active low
//     start    : request an evaluation (accepted in IDLE, or in DONE for
//                back-to-back relaunch)
//     target   : expected truth table, bit v*N_OUT+j = output j for vector v
//     dut_in   : registered vector driven to the individual
//     dut_out  : individual outputs
//     busy     : evaluation in progress
//     done     : one-cycle pulse, fitness valid
//     fitness  : number of matching output bits, held until the next DONE
//     observed : captured truth table (only with CGP_EVAL_CAPTURE_EN)
//
//   Optional feature macro: CGP_EVAL_CAPTURE_EN adds the observed port.
module cgp_fitness_eval
  import cgp_eval_pkg::*;
#(
  parameter  int N_IN          = DEF_N_IN,
  parameter  int N_OUT         = DEF_N_OUT,
  parameter  int SETTLE_CYCLES = 2,
  localparam int TBL_W         = table_width(N_IN, N_OUT),
  localparam int FIT_W         = fit_width(N_IN, N_OUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [TBL_W-1:0] target,
  output logic [N_IN-1:0]  dut_in,
  input  logic [N_OUT-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [FIT_W-1:0] fitness
`ifdef CGP_EVAL_CAPTURE_EN
  ,
  output logic [TBL_W-1:0] observed
`endif
);

  localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int POP_W = $clog2(N_OUT + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

  eval_state_t state, next_state;

  logic [TBL_W-1:0] target_q;
  logic [FIT_W-1:0] acc;
  logic [FIT_W-1:0] acc_next;
  logic [N_IN-1:0]  v;
  logic [CNT_W-1:0] cnt;
  logic             launch;
  logic             last_vec;
  logic [N_OUT-1:0] match;
  logic [POP_W-1:0] match_count;

  assign dut_in   = v;
  assign last_vec = (v == {N_IN{1'b1}});

  // A bit matches when the sampled output equals the expected output.
  assign match = ~(dut_out ^ target_q[int'(v) * N_OUT +: N_OUT]);

  cgp_popcount #(
    .W (N_OUT)
  ) u_popcount (
    .bits  (match),
    .count (match_count)
  );

  assign acc_next = acc + FIT_W'(match_count);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // SETTLE lasts SETTLE_CYCLES cycles and SAMPLE one more, so each vector is
  // held for SETTLE_CYCLES+1 cycles. DONE also accepts start so a held start
  // relaunches straight out of the done cycle.
  always_comb begin
    next_state = state;
    launch     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          launch     = 1'b1;
          next_state = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
        end
      end
      SETTLE: begin
        busy = 1'b1;
        if (cnt <= CNT_W'(1)) begin
          next_state = SAMPLE;
        end
      end
      SAMPLE: begin
        busy = 1'b1;
        if (last_vec) begin
          next_state = DONE;
        end else begin
          next_state = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          launch     = 1'b1;
          next_state = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // fitness is loaded on the edge leaving the last SAMPLE so it is already
  // valid during the DONE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target_q <= '0;
      acc      <= '0;
      v        <= '0;
      cnt      <= '0;
      fitness  <= '0;
`ifdef CGP_EVAL_CAPTURE_EN
      observed <= '0;
`endif
    end else if (launch) begin
      target_q <= target;
      acc      <= '0;
      v        <= '0;
      cnt      <= SETTLE_LOAD;
`ifdef CGP_EVAL_CAPTURE_EN
      observed <= '0;
`endif
    end else begin
      case (state)
        SETTLE: begin
          cnt <= cnt - CNT_W'(1);
        end
        SAMPLE: begin
          acc <= acc_next;
`ifdef CGP_EVAL_CAPTURE_EN
          observed[int'(v) * N_OUT +: N_OUT] <= dut_out;
`endif
          if (last_vec) begin
            fitness <= acc_next;
          end else begin
            v   <= v + N_IN'(1);
            cnt <= SETTLE_LOAD;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cgp_fitness_eval.sv
// tb_cgp_fitness_eval
//   Self-checking bench for cgp_fitness_eval with default parameters
//   (N_IN=4, N_OUT=4, SETTLE_CYCLES=2). The individual is modelled as a
//   wire loopback (dut_out = dut_in). Expected fitness values come from a
//   reference model and go through a scoreboard queue.
module tb_cgp_fitness_eval;

  localparam int N_IN   = 4;
  localparam int N_OUT  = 4;
  localparam int TBL_W  = 64;
  localparam int FIT_W  = 7;
  localparam int LAT    = 49;   // start edge .. done cycle, inclusive
  localparam int BUDGET = 200;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [TBL_W-1:0] target;
  logic [N_IN-1:0]  dut_in;
  logic [N_OUT-1:0] dut_out;
  logic             busy;
  logic             done;
  logic [FIT_W-1:0] fitness;
`ifdef CGP_EVAL_CAPTURE_EN
  logic [TBL_W-1:0] observed;
`endif

  int total = 0;
  int bad   = 0;
  int done_count = 0;
  int exp_q[$];

  cgp_fitness_eval dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .target   (target),
    .dut_in   (dut_in),
    .dut_out  (dut_out),
    .busy     (busy),
    .done     (done),
    .fitness  (fitness)
`ifdef CGP_EVAL_CAPTURE_EN
    ,
    .observed (observed)
`endif
  );

  assign dut_out = dut_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_count++;
  end

  function automatic logic [TBL_W-1:0] identity_table();
    logic [TBL_W-1:0] t;
    for (int vv = 0; vv < 16; vv++) t[vv*4 +: 4] = 4'(vv);
    return t;
  endfunction

  // Loopback reference: output j for vector v is bit j of v.
  function automatic int model_fitness(input logic [TBL_W-1:0] tgt);
    int f;
    logic [3:0] vec;
    f = 0;
    for (int vv = 0; vv < 16; vv++) begin
      vec = 4'(vv);
      for (int j = 0; j < 4; j++) begin
        if (vec[j] == tgt[vv*4 + j]) f++;
      end
    end
    return f;
  endfunction

  // Advance until done is seen; lat = cycles from the first edge, -1 on timeout.
  task automatic wait_done(input bit hold_start, output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(posedge clk); #1;
      if (c == 1 && !hold_start) start = 1'b0;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    target = identity_table();
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    total++; if (fitness !== 7'd0) begin bad++; $display("[TB] FAIL reset_fitness got=%0d want=0", fitness); end
    total++; if (dut_in !== 4'd0) begin bad++; $display("[TB] FAIL reset_dut_in got=%0d want=0", dut_in); end
`ifdef CGP_EVAL_CAPTURE_EN
    total++; if (observed !== '0) begin bad++; $display("[TB] FAIL reset_observed got=%h want=0", observed); end
`endif
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_no_launch busy=%b want=0", busy); end
  endtask

  task automatic run_one(input string name, input logic [TBL_W-1:0] tgt);
    int lat, got, exp_f;
    bit busy_ok;
    target = tgt;
    start  = 1'b1;
    exp_q.push_back(model_fitness(tgt));
    wait_done(1'b0, lat, busy_ok);
    total++; if (lat != LAT) begin bad++; $display("[TB] FAIL %s_latency got=%0d want=%0d", name, lat, LAT); end
    total++; if (!busy_ok) begin bad++; $display("[TB] FAIL %s_busy got=low_during_run want=high", name); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL %s_busy_in_done got=%b want=0", name, busy); end
    exp_f = exp_q.pop_front();
    got = int'(fitness);
    total++; if (got != exp_f) begin bad++; $display("[TB] FAIL %s_fitness got=%0d want=%0d", name, got, exp_f); end
`ifdef CGP_EVAL_CAPTURE_EN
    total++; if (observed !== identity_table()) begin bad++; $display("[TB] FAIL %s_observed got=%h want=%h", name, observed, identity_table()); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_loopback();
    int lat;
    bit busy_ok;
    // Separate run to spot-check the vector hold: vector 1 appears after 3 edges.
    target = identity_table();
    start  = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (dut_in !== 4'd0) begin bad++; $display("[TB] FAIL hold_vec0 got=%0d want=0", dut_in); end
    @(posedge clk); #1;
    total++; if (dut_in !== 4'd1) begin bad++; $display("[TB] FAIL hold_vec1 got=%0d want=1", dut_in); end
    wait_done(1'b0, lat, busy_ok);
    total++; if (lat < 0) begin bad++; $display("[TB] FAIL hold_run_done got=timeout want=done"); end
    @(posedge clk); #1;
    run_one("loopback", identity_table());
  endtask

  task automatic test_inverted();
    run_one("inverted", ~identity_table());
  endtask

  task automatic test_flip_and_ignore();
    logic [TBL_W-1:0] tgt;
    int lat, dc0, exp_f;
    tgt = identity_table();
    tgt[5*4 + 2] = ~tgt[5*4 + 2];
    run_one("flip", tgt);
    // Same table, but target scrambled mid-run and a stray start pulse.
    dc0 = done_count;
    target = tgt;
    start  = 1'b1;
    exp_q.push_back(model_fitness(tgt));
    lat = -1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(posedge clk); #1;
      if (c == 1)  start = 1'b0;
      if (c == 10) target = {$urandom, $urandom};
      if (c == 20) start = 1'b1;
      if (c == 21) start = 1'b0;
      if (done === 1'b1) begin lat = c; break; end
    end
    total++; if (lat != LAT) begin bad++; $display("[TB] FAIL midrun_latency got=%0d want=%0d", lat, LAT); end
    exp_f = exp_q.pop_front();
    total++; if (int'(fitness) != exp_f) begin bad++; $display("[TB] FAIL midrun_target_fitness got=%0d want=%0d", fitness, exp_f); end
    repeat (5) @(posedge clk);
    #1;
    total++; if (done_count - dc0 != 1) begin bad++; $display("[TB] FAIL ignored_start_dones got=%0d want=1", done_count - dc0); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL ignored_start_busy got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, exp_f;
    bit ok1, ok2;
    target = identity_table();
    start  = 1'b1;
    exp_q.push_back(model_fitness(target));
    exp_q.push_back(model_fitness(target));
    wait_done(1'b1, lat1, ok1);
    exp_f = exp_q.pop_front();
    total++; if (lat1 != LAT || int'(fitness) != exp_f) begin bad++; $display("[TB] FAIL b2b_first lat=%0d fit=%0d want lat=%0d fit=%0d", lat1, fitness, LAT, exp_f); end
    wait_done(1'b1, lat2, ok2);
    start = 1'b0;
    total++; if (lat2 != LAT) begin bad++; $display("[TB] FAIL b2b_gap got=%0d want=%0d", lat2, LAT); end
    total++; if (!ok2) begin bad++; $display("[TB] FAIL b2b_busy got=low_during_run want=high"); end
    exp_f = exp_q.pop_front();
    total++; if (int'(fitness) != exp_f) begin bad++; $display("[TB] FAIL b2b_second_fitness got=%0d want=%0d", fitness, exp_f); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle busy=%b want=0", busy); end
  endtask

  task automatic test_reset_midrun();
    int dc0;
    bit reached;
    target = identity_table();
    start  = 1'b1;
    exp_q.push_back(model_fitness(target));
    reached = 1'b0;
    for (int c = 1; c <= BUDGET; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      if (dut_in === 4'd7) begin reached = 1'b1; break; end
    end
    total++; if (!reached) begin bad++; $display("[TB] FAIL midrun_reach_v7 got=timeout want=v7"); end
    dc0 = done_count;
    rst_n = 1'b0;
    @(posedge clk); #1;
    // The in-flight evaluation is discarded, so its expectation is dropped.
    exp_q.delete();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy got=%b want=0", busy); end
    total++; if (dut_in !== 4'd0) begin bad++; $display("[TB] FAIL midrst_dut_in got=%0d want=0", dut_in); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL midrst_done got=%b want=0", done); end
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    total++; if (done_count != dc0) begin bad++; $display("[TB] FAIL midrst_no_done got=%0d want=0", done_count - dc0); end
    total++; if (fitness !== 7'd0) begin bad++; $display("[TB] FAIL midrst_fitness got=%0d want=0", fitness); end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    target = '0;
    test_reset();
    test_loopback();
    test_inverted();
    test_flip_and_ignore();
    test_back_to_back();
    test_reset_midrun();
    total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
